// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline controller state encoding.
// No logic; imported by the controller, its interface and the hazard detector.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        HALTED     = 2'd3
    } pctrl_state_t;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard inputs and latch-control outputs for the pipeline controller.
// Pure wiring; ctrl is the controller side, tb drives the hazard inputs.
interface pipeline_ctrl_if;
    import cpu_types_pkg::*;

    logic         ihit;
    logic         dhit;
    logic         exmem_dREN;
    logic         exmem_dWEN;
    logic         exmem_redirect;
    logic         exmem_halt;
    logic         idex_memread;
    regbits_t     idex_rt;
    regbits_t     ifid_rs;
    regbits_t     ifid_rt;

    logic         pc_enable;
    logic         ifid_enable;
    logic         idex_enable;
    logic         exmem_enable;
    logic         memwb_enable;
    logic         ifid_flush;
    logic         idex_flush;
    logic         exmem_flush;
    logic         halt;
    pctrl_state_t state;
    logic [15:0]  stall_cycles;

    modport ctrl (
        input  ihit, dhit, exmem_dREN, exmem_dWEN, exmem_redirect, exmem_halt,
               idex_memread, idex_rt, ifid_rs, ifid_rt,
        output pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
               ifid_flush, idex_flush, exmem_flush, halt, state, stall_cycles
    );

    modport tb (
        output ihit, dhit, exmem_dREN, exmem_dWEN, exmem_redirect, exmem_halt,
               idex_memread, idex_rt, ifid_rs, ifid_rt,
        input  pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
               ifid_flush, idex_flush, exmem_flush, halt, state, stall_cycles
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard compare: load in EX writes a register the ID instruction reads.
// Combinational, zero latency; $0 is never a hazard since it is hardwired.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_memread,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     hazard
);

    assign hazard = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: PC/latch enables and flushes, halt, stall counter.
// Outputs combinational from state and inputs (zero latency); stalls by dropping enables.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic          CLK,
    input  logic          nRST,
    pipeline_ctrl_if.ctrl pcif
);

    pctrl_state_t state_q, state_d;
    logic [15:0]  stall_q;
    logic         hazard;
    logic         mem_busy;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_fl, idex_fl, exmem_fl;

    load_use_detect u_lud (
        .idex_memread (pcif.idex_memread),
        .idex_rt      (pcif.idex_rt),
        .ifid_rs      (pcif.ifid_rs),
        .ifid_rt      (pcif.ifid_rt),
        .hazard       (hazard)
    );

    assign mem_busy = (pcif.exmem_dREN || pcif.exmem_dWEN) && !pcif.dhit;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = RUN;
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        ifid_fl  = 1'b0;
        idex_fl  = 1'b0;
        exmem_fl = 1'b0;

        case (state_q)
            HALTED: begin
                state_d = HALTED;
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            end
            MEM_WAIT: begin
                if (pcif.exmem_halt) begin
                    state_d = HALTED;
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                end else if (!pcif.dhit) begin
                    state_d = MEM_WAIT;
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                end
            end
            default: begin
                if (pcif.exmem_halt) begin
                    state_d = HALTED;
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                end else if (mem_busy) begin
                    state_d = MEM_WAIT;
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                end else if (pcif.exmem_redirect) begin
                    ifid_fl  = 1'b1;
                    idex_fl  = 1'b1;
                    exmem_fl = 1'b1;
                // The bubble for a load is already in flight while in LOAD_STALL.
                end else if (hazard && (state_q == RUN)) begin
                    state_d = LOAD_STALL;
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_fl = 1'b1;
                end else if (!pcif.ihit) begin
                    pc_en   = 1'b0;
                    ifid_fl = 1'b1;
                end
            end
        endcase
    end

    // A flushed latch never also updates with the incoming data.
    assign pcif.pc_enable    = pc_en;
    assign pcif.ifid_enable  = ifid_en  && !ifid_fl;
    assign pcif.idex_enable  = idex_en  && !idex_fl;
    assign pcif.exmem_enable = exmem_en && !exmem_fl;
    assign pcif.memwb_enable = memwb_en;
    assign pcif.ifid_flush   = ifid_fl;
    assign pcif.idex_flush   = idex_fl;
    assign pcif.exmem_flush  = exmem_fl;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_q <= '0;
        end else if ((state_q != HALTED) && !pc_en && (stall_q != STALL_MAX)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign pcif.halt         = (state_q == HALTED);
    assign pcif.state        = state_q;
    assign pcif.stall_cycles = stall_q;

endmodule
